// File: rtl/stadium_pkg.sv
// Shared types and constants for the stadium gate arbiter: result codes,
// FSM states, gate encodings and the ticket side-classification helper.
package stadium_pkg;

  typedef enum logic [1:0] {
    RES_OK         = 2'b00,
    RES_WRONG_GATE = 2'b01,
    RES_FULL       = 2'b10,
    RES_EMPTY      = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] HOME_MIN_ONES = 3'd3;
  localparam logic       GATE_HOME     = 1'b0;
  localparam logic       GATE_AWAY     = 1'b1;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt = cnt + 3'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/stadium_gate_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting lane above ptr, wrapping.
module rr_arbiter #(
  parameter int N_LANES = 4,
  localparam int IDX_W  = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the lane closest above ptr wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = N_LANES; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_LANES);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stadium_gate_arbiter.sv
// Round-robin arbiter sharing one ticket validator and home/away counters
// between scanner lanes. Optional macro REJECT_CNT_EN adds rejCount output.
module stadium_gate_arbiter
  import stadium_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CAP_H   = 200,
  parameter int CAP_A   = 200
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_LANES-1:0]     req,
  input  logic [5*N_LANES-1:0]   ticketID,
  input  logic [N_LANES-1:0]     gate,
  input  logic [N_LANES-1:0]     mode,
  output logic [N_LANES-1:0]     ack,
  output logic [1:0]             result,
  output logic [7:0]             numOfFanInH,
  output logic [7:0]             numOfFanInA,
  output logic                   gateWar,
  output logic                   busy
`ifdef REJECT_CNT_EN
  ,output logic [7:0]            rejCount
`endif
);

  localparam int IDX_W = $clog2(N_LANES);
  localparam logic [7:0] CAP_H_C = 8'(CAP_H);
  localparam logic [7:0] CAP_A_C = 8'(CAP_A);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, lane_q, lane_d;
  logic [4:0]       tid_q, tid_d;
  logic             gate_q, gate_d, mode_q, mode_d;
  result_e          eval_res_q, eval_res_d, result_q, result_d;
  logic [7:0]       cnt_h_q, cnt_h_d, cnt_a_q, cnt_a_d;
  logic [N_LANES-1:0] ack_q, ack_d;
  logic             gate_war_q, gate_war_d;
`ifdef REJECT_CNT_EN
  logic [7:0]       rej_q, rej_d;
`endif

  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             away_side;

  rr_arbiter #(.N_LANES(N_LANES)) u_rr (
    .req         (req),
    .ptr         (ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // NOTE: every _d gets its hold value first, so no branch can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lane_d     = lane_q;
    tid_d      = tid_q;
    gate_d     = gate_q;
    mode_d     = mode_q;
    eval_res_d = eval_res_q;
    result_d   = result_q;
    cnt_h_d    = cnt_h_q;
    cnt_a_d    = cnt_a_q;
    ack_d      = '0;
    gate_war_d = gate_war_q;
`ifdef REJECT_CNT_EN
    rej_d      = rej_q;
`endif
    away_side  = (popcount5(tid_q) < HOME_MIN_ONES);

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          lane_d  = grant_idx;
          tid_d   = ticketID[5*grant_idx +: 5];
          gate_d  = gate[grant_idx];
          mode_d  = mode[grant_idx];
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (mode_q) begin
          if (gate_q != (away_side ? GATE_AWAY : GATE_HOME)) begin
            eval_res_d = RES_WRONG_GATE;
          end else if (!away_side) begin
            if (cnt_h_q == CAP_H_C) eval_res_d = RES_FULL;
            else begin
              cnt_h_d    = cnt_h_q + 8'd1;
              eval_res_d = RES_OK;
            end
          end else begin
            if (cnt_a_q == CAP_A_C) eval_res_d = RES_FULL;
            else begin
              cnt_a_d    = cnt_a_q + 8'd1;
              eval_res_d = RES_OK;
            end
          end
        end else if (gate_q == GATE_HOME) begin
          // Exits are charged to the side named by the gate, not the ticket.
          if (cnt_h_q == 8'd0) eval_res_d = RES_EMPTY;
          else begin
            cnt_h_d    = cnt_h_q - 8'd1;
            eval_res_d = RES_OK;
          end
        end else begin
          if (cnt_a_q == 8'd0) eval_res_d = RES_EMPTY;
          else begin
            cnt_a_d    = cnt_a_q - 8'd1;
            eval_res_d = RES_OK;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        ack_d[lane_q] = 1'b1;
        result_d      = eval_res_q;
        gate_war_d    = (eval_res_q == RES_WRONG_GATE);
`ifdef REJECT_CNT_EN
        if (eval_res_q != RES_OK && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
`endif
        ptr_d   = lane_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(N_LANES - 1);
      eval_res_q <= RES_OK;
      result_q   <= RES_OK;
      cnt_h_q    <= 8'd0;
      cnt_a_q    <= 8'd0;
      ack_q      <= '0;
      gate_war_q <= 1'b0;
`ifdef REJECT_CNT_EN
      rej_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      eval_res_q <= eval_res_d;
      result_q   <= result_d;
      cnt_h_q    <= cnt_h_d;
      cnt_a_q    <= cnt_a_d;
      ack_q      <= ack_d;
      gate_war_q <= gate_war_d;
`ifdef REJECT_CNT_EN
      rej_q      <= rej_d;
`endif
    end
  end

  // NOTE: the latched payload is always written in IDLE before EVAL reads it,
  // so these datapath flops carry no reset.
  always_ff @(posedge CLK) begin
    lane_q <= lane_d;
    tid_q  <= tid_d;
    gate_q <= gate_d;
    mode_q <= mode_d;
  end

  assign ack         = ack_q;
  assign result      = result_q;
  assign numOfFanInH = cnt_h_q;
  assign numOfFanInA = cnt_a_q;
  assign gateWar     = gate_war_q;
  assign busy        = (state_q != IDLE);
`ifdef REJECT_CNT_EN
  assign rejCount    = rej_q;
`endif

endmodule

// File: tb/tb_stadium_gate_arbiter.sv
// Self-checking bench for stadium_gate_arbiter: directed scenarios plus
// randomized traffic checked against a transaction-level occupancy model.
module tb_stadium_gate_arbiter;

  localparam int N     = 4;
  localparam int CAP_H = 8;
  localparam int CAP_A = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   req = '0;
  logic [5*N-1:0] ticketID = '0;
  logic [N-1:0]   gate = '0;
  logic [N-1:0]   mode = '0;
  logic [N-1:0]   ack;
  logic [1:0]     result;
  logic [7:0]     numOfFanInH, numOfFanInA;
  logic           gateWar, busy;
`ifdef REJECT_CNT_EN
  logic [7:0]     rejCount;
`endif

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  int m_h, m_a, m_last, m_rej;
  bit m_gw;

  stadium_gate_arbiter #(.N_LANES(N), .CAP_H(CAP_H), .CAP_A(CAP_A)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .ticketID    (ticketID),
    .gate        (gate),
    .mode        (mode),
    .ack         (ack),
    .result      (result),
    .numOfFanInH (numOfFanInH),
    .numOfFanInA (numOfFanInA),
    .gateWar     (gateWar),
    .busy        (busy)
`ifdef REJECT_CNT_EN
    ,.rejCount   (rejCount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_h = 0; m_a = 0; m_last = N - 1; m_rej = 0; m_gw = 1'b0;
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_exec(input int l, output logic [1:0] er);
    logic [4:0] t;
    bit away, g, m;
    t    = ticketID[5*l +: 5];
    g    = gate[l];
    m    = mode[l];
    away = ($countones(t) < 3);
    if (m) begin
      if (g != away) er = 2'b01;
      else if (!away) begin
        if (m_h == CAP_H) er = 2'b10; else begin m_h++; er = 2'b00; end
      end else begin
        if (m_a == CAP_A) er = 2'b10; else begin m_a++; er = 2'b00; end
      end
    end else if (!g) begin
      if (m_h == 0) er = 2'b11; else begin m_h--; er = 2'b00; end
    end else begin
      if (m_a == 0) er = 2'b11; else begin m_a--; er = 2'b00; end
    end
    m_gw = (er == 2'b01);
    if (er != 2'b00 && m_rej < 255) m_rej++;
    m_last = l;
  endtask

  task automatic set_lane(input int l, input logic [4:0] t, input logic g, input logic m);
    ticketID[5*l +: 5] = t;
    gate[l] = g;
    mode[l] = m;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  task automatic wait_ack(output int l, output int cyc);
    l = -1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (|ack) begin
        for (int b = 0; b < N; b++) if (ack[b]) l = b;
        return;
      end
    end
  endtask

  // Drives one transaction through the DUT and advances the model.
  task automatic run_txn(input bit drop, output int exp_l, output int l,
                         output int cyc, output logic [1:0] er,
                         output logic [N-1:0] exp_ack);
    exp_l   = model_pick(req);
    er      = 2'b00;
    exp_ack = '0;
    if (exp_l >= 0) begin
      model_exec(exp_l, er);
      exp_ack[exp_l] = 1'b1;
    end
    wait_ack(l, cyc);
    if (drop && l >= 0) req[l] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ack, result, numOfFanInH, numOfFanInA, gateWar, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b res=%b h=%0d a=%0d gw=%b busy=%b, all must be 0",
               ack, result, numOfFanInH, numOfFanInA, gateWar, busy);
    end
`ifdef REJECT_CNT_EN
    total++;
    if (rejCount !== 8'd0) begin
      bad++; $display("FAIL reset_rej: got %0d want 0", rejCount);
    end
`endif
  endtask

  task automatic test_basic();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    set_lane(0, 5'b11100, 1'b0, 1'b1);
    req[0] = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_eval: got %b want 1", busy); end
    wait_ack(l, cyc);
    if (l >= 0) req[l] = 1'b0;
    total++;
    if (ack !== 4'b0001 || cyc != 2) begin
      bad++; $display("FAIL home_entry_ack: ack=%b after %0d more edges, want 0001 after 2", ack, cyc);
    end
    total++;
    if (result !== 2'b00 || numOfFanInH !== 8'd1 || numOfFanInA !== 8'd0 || gateWar !== 1'b0) begin
      bad++; $display("FAIL home_entry: res=%b h=%0d a=%0d gw=%b want 00 1 0 0",
                      result, numOfFanInH, numOfFanInA, gateWar);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_ack: got %b want 0", busy); end
    m_h = 1; m_last = 0;

    set_lane(1, 5'b00011, 1'b0, 1'b1);
    req[1] = 1'b1;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (ack !== ea || cyc != 3 || result !== 2'b01 || gateWar !== 1'b1 ||
        numOfFanInH !== 8'd1 || numOfFanInA !== 8'd0) begin
      bad++; $display("FAIL wrong_gate: ack=%b cyc=%0d res=%b gw=%b h=%0d a=%0d want %b 3 01 1 1 0",
                      ack, cyc, result, gateWar, numOfFanInH, numOfFanInA, ea);
    end

    set_lane(2, 5'b00011, 1'b1, 1'b1);
    req[2] = 1'b1;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (ack !== ea || result !== 2'b00 || gateWar !== 1'b0 || numOfFanInA !== 8'd1) begin
      bad++; $display("FAIL away_entry: ack=%b res=%b gw=%b a=%0d want %b 00 0 1",
                      ack, result, gateWar, numOfFanInA, ea);
    end
  endtask

  task automatic test_round_robin();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 5'b10101, 1'b0, 1'b1);
    req = '1;
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, el, l, cyc, er, ea);
      total++;
      if (l != i % N || ack !== ea || cyc != 3 || result !== 2'b00) begin
        bad++; $display("FAIL rr_order_%0d: lane=%0d cyc=%0d res=%b want lane %0d cyc 3 res 00",
                        i, l, cyc, result, i % N);
      end
    end
    total++;
    if (numOfFanInH !== 8'(m_h) || m_h != 8) begin
      bad++; $display("FAIL rr_count: h=%0d want 8", numOfFanInH);
    end
  endtask

  task automatic test_full();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    req = 4'b0001;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (ack !== ea || result !== 2'b10 || numOfFanInH !== 8'(CAP_H)) begin
      bad++; $display("FAIL home_full: ack=%b res=%b h=%0d want %b 10 %0d",
                      ack, result, numOfFanInH, ea, CAP_H);
    end
`ifdef REJECT_CNT_EN
    total++;
    if (rejCount !== 8'(m_rej)) begin
      bad++; $display("FAIL rej_full: got %0d want %0d", rejCount, m_rej);
    end
`endif
  endtask

  task automatic test_empty();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    set_lane(3, 5'b11111, 1'b1, 1'b0);
    req = 4'b1000;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (ack !== ea || result !== 2'b11 || numOfFanInA !== 8'd0) begin
      bad++; $display("FAIL away_empty: ack=%b res=%b a=%0d want %b 11 0", ack, result, numOfFanInA, ea);
    end
`ifdef REJECT_CNT_EN
    total++;
    if (rejCount !== 8'(m_rej)) begin
      bad++; $display("FAIL rej_empty: got %0d want %0d", rejCount, m_rej);
    end
`endif
    set_lane(1, 5'b00000, 1'b0, 1'b0);
    req = 4'b0010;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (ack !== ea || result !== 2'b00 || numOfFanInH !== 8'(CAP_H - 1)) begin
      bad++; $display("FAIL home_exit: ack=%b res=%b h=%0d want %b 00 %0d",
                      ack, result, numOfFanInH, ea, CAP_H - 1);
    end
  endtask

  task automatic test_reset_mid();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    int acks;
    set_lane(2, 5'b11110, 1'b0, 1'b1);
    req = 4'b0100;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    total++;
    if (ack !== '0 || busy !== 1'b0 || numOfFanInH !== 8'd0 || numOfFanInA !== 8'd0) begin
      bad++; $display("FAIL reset_mid: ack=%b busy=%b h=%0d a=%0d want 0 0 0 0",
                      ack, busy, numOfFanInH, numOfFanInA);
    end
    req = '0;
    acks = 0;
    repeat (4) begin @(posedge CLK); #1; if (|ack) acks++; end
    total++;
    if (acks != 0) begin bad++; $display("FAIL reset_mid_noack: saw %0d acks want 0", acks); end
    for (int i = 0; i < N; i++) set_lane(i, 5'b01111, 1'b0, 1'b1);
    req = '1;
    run_txn(1'b1, el, l, cyc, er, ea);
    total++;
    if (l != 0 || ack !== ea || numOfFanInH !== 8'd1) begin
      bad++; $display("FAIL reset_mid_first: lane=%0d h=%0d want lane 0 h 1", l, numOfFanInH);
    end
    req = '0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    int el, l, cyc; logic [1:0] er; logic [N-1:0] ea;
    do_reset();
    req = '0;
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 2) != 0)) begin
          set_lane(i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 9) < 6));
          req[i] = 1'b1;
        end
      end
      run_txn($urandom_range(0, 3) != 0, el, l, cyc, er, ea);
      total++;
      if (l != el || ack !== ea || cyc != 3 || result !== er || numOfFanInH !== 8'(m_h) ||
          numOfFanInA !== 8'(m_a) || gateWar !== m_gw) begin
        bad++; $display("FAIL random_%0d: lane=%0d cyc=%0d res=%b h=%0d a=%0d gw=%b want lane %0d cyc 3 res %b h %0d a %0d gw %b",
                        it, l, cyc, result, numOfFanInH, numOfFanInA, gateWar,
                        el, er, m_h, m_a, m_gw);
      end
`ifdef REJECT_CNT_EN
      total++;
      if (rejCount !== 8'(m_rej)) begin
        bad++; $display("FAIL random_rej_%0d: got %0d want %0d", it, rejCount, m_rej);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_full();
    test_empty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stadium_gate_arbiter.md
Name: stadium_gate_arbiter

Overview:
- Shares one ticket validator and the home/away fan counters between N_LANES turnstile scanner lanes.
- Grants one lane at a time in round-robin order, classifies the ticket, checks the gate and capacity, updates the counters, and returns an ack with a result code.
- Sits between the scanner lanes and the stadium occupancy displays.

Parameters:
- N_LANES, 4, number of scanner lanes (2..8).
- CAP_H, 200, maximum home fans admitted (1..255).
- CAP_A, 200, maximum away fans admitted (1..255).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- req  in  N_LANES  per-lane request; held high with payload stable until ack.
- ticketID  in  5*N_LANES  lane i payload is bits [5i+4:5i].
- gate  in  N_LANES  per-lane gate used: 0 = home, 1 = away.
- mode  in  N_LANES  per-lane direction: 1 = entry, 0 = exit.
- ack  out  N_LANES  one-hot, 1-cycle completion pulse.
- result  out  2  valid while ack is high: 00 OK, 01 WRONG_GATE, 10 FULL, 11 EMPTY.
- numOfFanInH  out  8  home occupancy.
- numOfFanInA  out  8  away occupancy.
- gateWar  out  1  wrong-gate warning.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Outputs: ack=0, result=00, counts=0, gateWar=0, busy=0.
  - Internal: FSM=IDLE, rr pointer=N_LANES-1, so lane 0 has first priority.
  - RST mid-transaction aborts it: no counter update, no ack.
- FSM IDLE:
  - If any req is high, grant the first requesting lane searching upward from pointer+1, wrapping at N_LANES.
  - Latch that lane's index, ticketID, gate and mode; go to EVAL.
- FSM EVAL:
  - Compute ones = popcount(ticketID). Side is home if ones>=3, else away.
  - Entry (mode=1):
    - Gate does not match side (home needs gate 0, away needs gate 1) -> WRONG_GATE.
    - Otherwise, that side's count == its CAP -> FULL.
    - Otherwise -> OK, increment that side's count.
  - Exit (mode=0):
    - Side is selected by the latched gate (0 home, 1 away).
    - Count == 0 -> EMPTY, no decrement.
    - Otherwise -> OK, decrement.
  - Counters never wrap.
  - Go to RESP.
- FSM RESP:
  - Drive ack[granted]=1 and result; counters already show the updated value.
  - Update pointer to the granted lane; go to IDLE.
- gateWar:
  - Set to 1 when a transaction completes with WRONG_GATE.
  - Cleared when a transaction completes with any other result.
  - Otherwise holds its value.
  - Updates in the same cycle as ack.
- Latency:
  - req sampled in IDLE at edge t; ack is high during the cycle after edge t+2.
  - Throughput is one transaction per 3 cycles.
- Requester rule:
  - A lane drops req on the edge at which it sees ack.
  - The returning IDLE cycle therefore sees that lane's req low.
  - A req that stays high is re-served as a new transaction once round-robin order reaches that lane again.
- Non-granted requests are not affected by the transaction in progress.
- req changes outside IDLE are ignored until the FSM returns to IDLE.
- All requests simultaneously: service order is strict rotation 0,1,2,3,0,...

Optional Feature:
- Macro: REJECT_CNT_EN.
- Defined:
  - Adds output rejCount[7:0], reset to 0.
  - Increments in the RESP cycle of every non-OK transaction.
  - Saturates at 255.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package stadium_pkg:
  - result codes RES_OK, RES_WRONG_GATE, RES_FULL, RES_EMPTY.
  - state enum IDLE/EVAL/RESP.
  - HOME_MIN_ONES=3.
  - gate encodings GATE_HOME=0, GATE_AWAY=1.
- Sub-module rr_arbiter: parameterised N_LANES round-robin picker taking req vector and pointer, returning grant index and a valid flag. Purely combinational; the pointer register stays in the top.

Test Plan:
- After reset, lane0 req, ticketID=5'b11100, gate=0, mode=1 -> ack[0] high 3rd cycle, result=00, numOfFanInH=1, gateWar=0.
- Lane1 ticketID=5'b00011, gate=0, mode=1 -> result=01, counts unchanged, gateWar=1. Then a valid away entry -> gateWar=0, numOfFanInA=1.
- All 4 lanes req valid home entries continuously for 8 transactions -> acks in order 0,1,2,3,0,1,2,3; numOfFanInH=8.
- CAP_H=2, three valid home entries -> results 00,00,10; numOfFanInH stays 2.
- Exit at gate=1 with numOfFanInA=0 -> result=11, count stays 0. With REJECT_CNT_EN, rejCount increments by 1.
- RST asserted during EVAL -> no ack; counts=0, FSM in IDLE next cycle; next transaction grants lane 0 first.
